// File: rtl/fdt_programmable.sv
// rtl/fdt_programmable.sv - programmable ISO 14443-3A PICC frame-delay-time trigger generator
// Optional FDT_TX_READY_EN adds tx_ready/late and a DEFER state that retries on later 128-tick slots.
module fdt_programmable #(
  parameter int N_WIDTH       = 8,
  parameter int TIMING_ADJUST = 0,
  parameter int N_MIN         = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pause_n_synchronised,
  input  logic               last_rx_bit,
  input  logic [N_WIDTH-1:0] n_value,
  input  logic               enable,
`ifdef FDT_TX_READY_EN
  input  logic               tx_ready,
  output logic               late,
`endif
  output logic               trigger,
  output logic               counting
);

  localparam int CW = N_WIDTH + 8;
  localparam logic [N_WIDTH-1:0] N_MIN_W = N_WIDTH'(N_MIN);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PAUSED   = 2'd1,
    COUNTING = 2'd2,
    DEFER    = 2'd3
  } state_t;

  state_t             state;
  logic               pause_q;
  logic [N_WIDTH-1:0] n_lat;
  logic [CW-1:0]      counter;
  logic [CW-1:0]      target;
  logic               pause_rise;
  logic               pause_fall;
  logic               target_hit;
`ifdef FDT_TX_READY_EN
  logic [6:0]         slot;
`endif

  assign pause_rise = pause_n_synchronised & ~pause_q;
  assign pause_fall = ~pause_n_synchronised & pause_q;

  always_comb begin
    target = {1'b0, n_lat, 7'd0} + (last_rx_bit ? CW'(84) : CW'(20)) - CW'(TIMING_ADJUST);
  end

  // counter holds the number of edges since the one just before the pause rise,
  // so the registered trigger lands exactly on that edge + target
  assign target_hit = (counter == target - CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pause_q  <= 1'b0;
      n_lat    <= N_MIN_W;
      counter  <= '0;
      trigger  <= 1'b0;
      counting <= 1'b0;
`ifdef FDT_TX_READY_EN
      late     <= 1'b0;
      slot     <= '0;
`endif
    end else begin
      pause_q <= pause_n_synchronised;
      trigger <= 1'b0;
`ifdef FDT_TX_READY_EN
      late    <= 1'b0;
`endif
      if (!enable) begin
        state    <= IDLE;
        counter  <= '0;
        counting <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            counter  <= '0;
            counting <= 1'b0;
            if (pause_fall) state <= PAUSED;
          end
          PAUSED: begin
            counter <= '0;
            if (pause_rise) begin
              state    <= COUNTING;
              counter  <= CW'(1);
              counting <= 1'b1;
              n_lat    <= (n_value < N_MIN_W) ? N_MIN_W : n_value;
            end
          end
          COUNTING: begin
            if (pause_fall) begin
              state    <= PAUSED;
              counter  <= '0;
              counting <= 1'b0;
            end else if (target_hit) begin
`ifdef FDT_TX_READY_EN
              if (tx_ready) begin
                trigger  <= 1'b1;
                state    <= IDLE;
                counter  <= '0;
                counting <= 1'b0;
              end else begin
                late    <= 1'b1;
                state   <= DEFER;
                slot    <= '0;
                counter <= counter + CW'(1);
              end
`else
              trigger  <= 1'b1;
              state    <= IDLE;
              counter  <= '0;
              counting <= 1'b0;
`endif
            end else begin
              counter <= counter + CW'(1);
            end
          end
`ifdef FDT_TX_READY_EN
          DEFER: begin
            if (pause_fall) begin
              state    <= PAUSED;
              counter  <= '0;
              counting <= 1'b0;
            end else if (slot == 7'd127 && tx_ready) begin
              trigger  <= 1'b1;
              state    <= IDLE;
              counter  <= '0;
              counting <= 1'b0;
            end else begin
              counter <= counter + CW'(1);
              slot    <= slot + 7'd1;
            end
          end
`endif
          default: begin
            state    <= IDLE;
            counter  <= '0;
            counting <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/fdt_programmable.md
Name: fdt_programmable

Overview:
- Programmable frame-delay-time (FDT) generator for the ISO/IEC 14443-3A PICC transmit path. It is the parametrised successor of the fixed fdt block.
- Measures the delay from the last PCD pause (rising edge of pause_n_synchronised) to the PICC response. It pulses trigger to start modulation on the bit grid defined by FDT = n*128 + 84 or n*128 + 20 carrier ticks, selected by the last received bit.
- n is programmable at runtime. The fixed n=9 timing of anticollision/REQA frames is the special case.

Parameters:
- N_WIDTH, 8, width of n_value input.
- TIMING_ADJUST, 0, ticks subtracted from every target to compensate synchroniser and tx pipeline latency. Must be < 1172.
- N_MIN, 9, minimum n. n_value below N_MIN is treated as N_MIN.

Ports:
- clk  input  1  carrier-derived clock, one tick per fc period
- rst_n  input  1  asynchronous active-low reset
- pause_n_synchronised  input  1  synchronised PCD pause, low during pause
- last_rx_bit  input  1  value of last received data bit (1 selects +84, 0 selects +20)
- n_value  input  N_WIDTH  FDT multiplier n
- enable  input  1  high to arm generator
- trigger  output  1  single-cycle pulse: start response now
- counting  output  1  high while measuring an FDT

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE, counter 0, trigger 0, counting 0. Releasing rst_n mid-frame does not produce a trigger until a fresh pause rising edge is seen.
- Target arithmetic:
  - target = max(n_value, N_MIN)*128 + (last_rx_bit ? 84 : 20) - TIMING_ADJUST.
  - Counter width = N_WIDTH+8 bits (localparam), so the counter never wraps before the maximum target.
  - n_value is latched on the pause rising edge.
  - last_rx_bit is used live and must be stable by target.
- Timing: if pause_n_synchronised goes high just after clock edge E0, trigger goes high just after edge E0+target and low after E0+target+1.
- States:
  - IDLE: counting=0. A falling edge of pause_n_synchronised with enable=1 moves to PAUSED.
  - PAUSED: pause low. A rising edge moves to COUNTING, clears the counter and latches n.
  - COUNTING: counting=1, counter increments each tick.
    - A falling edge of pause_n_synchronised returns to PAUSED and discards the count. Any number of pauses may occur; only the last rising edge matters.
    - On reaching target: pulse trigger, go to IDLE.
- enable low in any state: return to IDLE next cycle, no trigger. An in-progress count is dropped.
- Simultaneous falling edge and target in the same cycle: the pause wins and no trigger is issued.
- The counter is held at 0 in IDLE (no free running).
- Exactly one trigger per frame; none without a preceding pause.

Optional Feature:
- Macro FDT_TX_READY_EN adds an input tx_ready (1 bit) and an output late (1 bit, reset 0).
- With the macro:
  - If tx_ready=0 when target is reached, the state moves to DEFER. trigger is withheld and late pulses for 1 cycle.
  - DEFER keeps counting. trigger fires at the next slot where tx_ready=1, with slots at target + k*128.
  - A pause falling edge or enable low aborts DEFER, same as COUNTING.
- Without the macro: no such ports; trigger fires at target unconditionally.

Test Plan:
- TIMING_ADJUST=0, n_value=9, last_rx_bit=0, pause low 5 ticks then high -> trigger exactly 1172 ticks after rise, single cycle, counting high throughout.
- Same with last_rx_bit=1 -> trigger at 1236. With n_value=20, last_rx_bit=1 -> trigger at 2644.
- n_value=3 -> clamped to 9, trigger at 1172 (last_rx_bit=0).
- Three pauses 400 ticks apart, last_rx_bit=1 -> trigger 1236 ticks after the final rise only. A pause starting at tick 1000 of a count -> no trigger for that count.
- No pause for 3000 ticks -> no trigger. enable low mid-count -> no trigger. rst_n low mid-count then released -> no trigger.
- With FDT_TX_READY_EN: tx_ready=0 at 1172, then tx_ready=1 -> late pulse at 1172, trigger at 1300. With tx_ready=1 throughout -> trigger at 1172, late never asserted.
